// File: rtl/inv_mix_columns.sv
// AES InvMixColumns stage for the decryption round.
// It accepts one 128-bit state, then transforms one 32-bit column per clock
// through a single shared GF(2^8) column datapath. The result is presented
// behind a valid/ready handshake.
module inv_mix_columns (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    localparam int W_DATA = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              col_q, col_d;
    // Column c sits in packed word 3-c, so column 0 is the top 32 bits.
    logic [3:0][31:0]        in_q, in_d;
    logic [3:0][31:0]        out_q, out_d;
    logic [31:0]             col_res;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Build the 09/0b/0d/0e products of one byte from a single xtime chain.
    function automatic logic [31:0] inv_products(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        // Packed as {09, 0b, 0d, 0e}.
        return {x8 ^ b, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ x4 ^ x2};
    endfunction

    // Apply the inverse MixColumns matrix to one column (s0,s1,s2,s3).
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [31:0] p0, p1, p2, p3;
        logic [7:0]  r0, r1, r2, r3;
        p0 = inv_products(c[31:24]);
        p1 = inv_products(c[23:16]);
        p2 = inv_products(c[15:8]);
        p3 = inv_products(c[7:0]);
        // The byte fields of pN are [31:24]=09, [23:16]=0b, [15:8]=0d, [7:0]=0e.
        r0 = p0[7:0]   ^ p1[23:16] ^ p2[15:8]  ^ p3[31:24];
        r1 = p0[31:24] ^ p1[7:0]   ^ p2[23:16] ^ p3[15:8];
        r2 = p0[15:8]  ^ p1[31:24] ^ p2[7:0]   ^ p3[23:16];
        r3 = p0[23:16] ^ p1[15:8]  ^ p2[31:24] ^ p3[7:0];
        return {r0, r1, r2, r3};
    endfunction

    // Shared column datapath. The counter selects the column through word index 3-col.
    always_comb begin
        col_res = inv_col(in_q[~col_q]);
    end

    // Next-state logic for the FSM, the column counter and the data registers.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        in_d    = in_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_d    = data_in;
                    col_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                out_d[~col_q] = col_res;
                col_d         = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. A reset aborts any block in flight and clears the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    // Accept only in IDLE, and never while reset is applied.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        data_out  = W_DATA'(out_q);
    end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed and round-trip bench for inv_mix_columns.
module tb_inv_mix_columns;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    int checks   = 0;
    int failures = 0;

    inv_mix_columns dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] tb_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns, used to build round-trip stimulus.
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a, b, c, d;
        for (int k = 0; k < 4; k++) begin
            a = s[127 - 32*k -: 8];
            b = s[119 - 32*k -: 8];
            c = s[111 - 32*k -: 8];
            d = s[103 - 32*k -: 8];
            r[127 - 32*k -: 8] = tb_xtime(a) ^ tb_xtime(b) ^ b ^ c ^ d;
            r[119 - 32*k -: 8] = a ^ tb_xtime(b) ^ tb_xtime(c) ^ c ^ d;
            r[111 - 32*k -: 8] = a ^ b ^ tb_xtime(c) ^ tb_xtime(d) ^ d;
            r[103 - 32*k -: 8] = tb_xtime(a) ^ a ^ b ^ c ^ tb_xtime(d);
        end
        return r;
    endfunction

    // Push one state in, wait for the result, check latency, then drain it.
    task automatic run_block(input string tag, input logic [127:0] din, output logic [127:0] dout);
        int wait_cyc;
        int lat;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        check_eq({tag, " in_ready before accept"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        data_in  = din;
        tick();
        in_valid = 1'b0;
        data_in  = '0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq({tag, " latency"}, 128'(lat), 128'(4));
        dout = data_out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [127:0] res;
    logic [127:0] vec_in  [3];
    logic [127:0] vec_exp [3];
    int           acc_cyc [3];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;

        // Reset state.
        tick();
        tick();
        check_eq("reset in_ready", 128'(in_ready), 128'(0));
        check_eq("reset out_valid", 128'(out_valid), 128'(0));
        check_eq("reset data_out", data_out, 128'h0);
        rst = 1'b0;
        #1;
        check_eq("in_ready after reset", 128'(in_ready), 128'(1));

        // Known vectors.
        run_block("vec1", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, res);
        check_eq("vec1 data", res, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
        check_eq("vec1 out_valid drop", 128'(out_valid), 128'(0));
        check_eq("vec1 in_ready back", 128'(in_ready), 128'(1));
        run_block("vec2", 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, res);
        check_eq("vec2 data", res, 128'hd4d4d4d5_2d26314c_00000000_ffffffff);

        // Backpressure.
        in_valid = 1'b1;
        data_in  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        tick();
        data_in = 128'hffffffff_ffffffff_ffffffff_ffffffff;
        for (int i = 0; i < 4; i++) tick();
        check_eq("bp out_valid rise", 128'(out_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            check_eq("bp data stable", data_out, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
            check_eq("bp out_valid stable", 128'(out_valid), 128'(1));
            check_eq("bp in_ready low", 128'(in_ready), 128'(0));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp out_valid drop", 128'(out_valid), 128'(0));
        check_eq("bp in_ready back", 128'(in_ready), 128'(1));

        // Back-to-back with out_ready tied high.
        vec_in[0]  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        vec_exp[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        vec_in[1]  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
        vec_exp[1] = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
        vec_in[2]  = 128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc;
        vec_exp[2] = 128'hc6c6c6c6_01010101_f20a225c_db135345;
        begin
            int na, nr, cyc;
            logic acc;
            na = 0;
            nr = 0;
            cyc = 0;
            in_valid  = 1'b1;
            data_in   = vec_in[0];
            out_ready = 1'b1;
            while (nr < 3 && cyc < 60) begin
                acc = in_ready && in_valid;
                if (out_valid) begin
                    check_eq($sformatf("b2b result %0d", nr), data_out, vec_exp[nr]);
                    nr++;
                end
                if (acc) begin
                    acc_cyc[na] = cyc;
                    na++;
                end
                tick();
                cyc++;
                if (acc) begin
                    if (na < 3) data_in = vec_in[na];
                    else        in_valid = 1'b0;
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check_eq("b2b result count", 128'(nr), 128'(3));
            check_eq("b2b accept count", 128'(na), 128'(3));
            if (na == 3) begin
                check_eq("b2b spacing 0-1", 128'(acc_cyc[1] - acc_cyc[0]), 128'(6));
                check_eq("b2b spacing 1-2", 128'(acc_cyc[2] - acc_cyc[1]), 128'(6));
            end
        end
        tick();

        // Reset mid-BUSY.
        begin
            logic seen;
            in_valid = 1'b1;
            data_in  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            rst = 1'b1;
            #1;
            check_eq("rst in_ready low", 128'(in_ready), 128'(0));
            tick();
            rst = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (out_valid) seen = 1'b1;
                tick();
            end
            check_eq("rst no out_valid", 128'(seen), 128'(0));
            check_eq("rst data_out cleared", data_out, 128'h0);
            check_eq("rst in_ready after", 128'(in_ready), 128'(1));
        end
        run_block("post-rst", 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, res);
        check_eq("post-rst data", res, 128'hd4d4d4d5_2d26314c_00000000_ffffffff);

        // Reset and in_valid together: nothing accepted.
        begin
            logic seen;
            rst      = 1'b1;
            in_valid = 1'b1;
            data_in  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
            tick();
            rst      = 1'b0;
            in_valid = 1'b0;
            seen     = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (out_valid) seen = 1'b1;
                tick();
            end
            check_eq("rst+valid no accept", 128'(seen), 128'(0));
            check_eq("rst+valid in_ready", 128'(in_ready), 128'(1));
        end

        // Round trip through the forward transform.
        for (int n = 0; n < 1000; n++) begin
            logic [127:0] orig;
            orig = {$urandom, $urandom, $urandom, $urandom};
            run_block("rt", mix_columns(orig), res);
            check_eq($sformatf("round trip %0d", n), res, orig);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns.md
# inv_mix_columns

Multi-cycle AES InvMixColumns stage for the decryption datapath: the inverse of the encryption MixColumns transform. Accepts one 128-bit state per valid/ready handshake. Multiplies each 32-bit column by the inverse MixColumns matrix over GF(2^8), one column per clock. Presents the result behind a valid/ready output handshake, so it drops in between InvShiftRows/InvSubBytes and AddRoundKey in the inverse cipher round.

## Interface
- `W_DATA`, 128, state width in bits (from `lib/opcodes.v`; fixed at 128, not overridable).
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream has a state on `data_in`.
- `in_ready` output 1: block can accept a state; high only in IDLE and low while `rst`=1.
- `data_in` input `W_DATA`: input state.
- `out_valid` output 1: `data_out` holds a completed result.
- `out_ready` input 1: downstream accepts `data_out`.
- `data_out` output `W_DATA`: result state, registered.

## Operation
- Byte k (0..15) is `data[127-8k -: 8]`. Column c (0..3) is bytes 4c..4c+3 = (s0,s1,s2,s3).
- Per column:
  - r0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - r1 = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
  - r2 = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
  - r3 = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
- All products are GF(2^8) mod x^8+x^4+x^3+x+1. Addition is XOR; integer `+`/`*` is forbidden.
- xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0). Products are built from the xtime chain:
  - x2=xtime(b), x4=xtime(x2), x8=xtime(x4)
  - 09=x8^b, 0b=x8^x2^b, 0d=x8^x4^b, 0e=x8^x4^x2
- One shared column datapath (4 input bytes -> 4 output bytes), muxed by a 2-bit column counter `col`.
- FSM:
  - IDLE: `in_ready`=1. On `in_valid`: latch `data_in` into the input register, set `col`=0, go to BUSY.
  - BUSY: each cycle, write column `col` of the result into `data_out`, then `col`++. When the column-3 write completes, go to DONE.
  - DONE: `out_valid`=1, `data_out` held stable. On `out_ready`, go to IDLE.
- `in_ready`=0 in BUSY and DONE. `data_in` is ignored outside the IDLE accept.
- A column is fully written in one cycle; no partial-byte states exist.

## Timing
- Reset values: state=IDLE, `col`=0, `out_valid`=0, `data_out`=128'h0, input register=0.
- Rst held high forces `in_ready`=0. `in_ready` rises in the first cycle after rst deasserts.
- Latency: accept at edge T gives `out_valid`=1 after edge T+4 (4 BUSY cycles).
- Throughput: if `out_ready` is tied high, DONE lasts 1 cycle and IDLE 1 cycle, giving one block per 6 cycles.
- Backpressure: `out_valid` and `data_out` must not change while `out_valid`=1 and `out_ready`=0, for any number of cycles.
- `out_ready` high outside DONE: no effect.
- `in_valid` high outside IDLE: no effect; upstream must hold its data.
- No input accept in the same cycle as the output handshake; the next accept is in the following IDLE cycle.
- `col` wraps 3->0 on BUSY exit.
- `data_out` content is only meaningful while `out_valid`=1. During BUSY it holds the partially updated result.
- Rst mid-operation (BUSY or DONE): abort at that edge, discard in-flight data, restore reset values. No `out_valid` pulse follows.
- Rst and `in_valid` in the same cycle: rst wins, nothing accepted.

## Test plan
- Known vector: accept 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - Expect `out_valid` 4 cycles after accept.
  - Expect `data_out`=128'hdb135345_f20a225c_01010101_c6c6c6c6.
- Second vector: 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff.
  - Expect 128'hd4d4d4d5_2d26314c_00000000_ffffffff.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `data_out` and `out_valid` stay stable; `in_ready`=0 throughout.
  - Raise `out_ready`: `out_valid` drops next cycle, `in_ready`=1.
- Back-to-back: `in_valid` and `out_ready` held high with 3 different states.
  - 3 correct results in order, accepts spaced exactly 6 cycles apart.
- Reset mid-BUSY: assert `rst` for 1 cycle 2 cycles after accept.
  - `out_valid` never rises for that block; `data_out`=0; `in_ready`=1 after reset.
  - A fresh vector then completes correctly.
- Round-trip: 1000 random states through the encryption MixColumns golden model, then through this block.
  - Output equals the original state for every sample.
